// File: rtl/ps2_keyseq_ctrl_if.sv
// Key-event bus between the PS/2 sequencer and its consumer: byte strobe in, buffered events out.
// The master modport belongs to the byte source and consumer side; the slave modport belongs to the sequencer.
interface ps2_keyseq_ctrl_if;
    logic       iTrig;
    logic [7:0] iData;
    logic       iAck;
    logic       iClr;
    logic       oValid;
    logic [7:0] oKey;
    logic       oExt;
    logic       oBreak;
    logic [2:0] oMod;
    logic       oOverflow;

    modport master (
        output iTrig, iData, iAck, iClr,
        input  oValid, oKey, oExt, oBreak, oMod, oOverflow
    );

    modport slave (
        input  iTrig, iData, iAck, iClr,
        output oValid, oKey, oExt, oBreak, oMod, oOverflow
    );
endinterface

// File: rtl/ps2_keyseq_ctrl.sv
// Assembles set-2 scan bytes into key events, tracks modifiers and queues events in a small FIFO.
// Latency: 1 cycle from the final byte strobe to the FIFO head; a full FIFO drops new events and sets a sticky overflow flag.
module ps2_keyseq_ctrl #(
    parameter int DEPTH_LOG2 = 2,
    parameter int SKIP_PAUSE = 7
) (
    input logic             CLOCK,
    input logic             RESET,
    ps2_keyseq_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = (SKIP_PAUSE < 2) ? 1 : $clog2(SKIP_PAUSE + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [SW-1:0]       SKIP_INIT = SW'(SKIP_PAUSE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_SKIP
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   cnt, cnt_nxt;
    // flag order: {RAlt, LAlt, RCtrl, LCtrl, RShift, LShift}
    logic [5:0]      flags, flags_nxt;

    logic            emit;
    logic [7:0]      ev_key;
    logic            ev_ext;
    logic            ev_brk;
    logic            is_ext;
    logic            is_brk;
    logic            reserved;

    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  overflow;

    assign is_ext = (state == S_EXT) || (state == S_EXTBRK);
    assign is_brk = (state == S_BRK) || (state == S_EXTBRK);

    always_comb begin
        reserved = 1'b0;
        case (bus.iData)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: reserved = 1'b1;
            default: reserved = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            flags <= flags_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flags_nxt = flags;
        emit      = 1'b0;
        ev_key    = bus.iData;
        ev_ext    = 1'b0;
        ev_brk    = 1'b0;
        if (bus.iTrig) begin
            if (state == S_SKIP) begin
                // Pause tail carries bytes that look like modifiers; swallow them blindly.
                if (cnt <= SW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end else if (reserved) begin
                state_nxt = S_IDLE;
            end else if (bus.iData == 8'hE0) begin
                state_nxt = S_EXT;
            end else if (bus.iData == 8'hF0) begin
                state_nxt = is_ext ? S_EXTBRK : S_BRK;
            end else if (bus.iData == 8'hE1 && state == S_IDLE) begin
                emit      = 1'b1;
                state_nxt = S_SKIP;
                cnt_nxt   = SKIP_INIT;
            end else begin
                state_nxt = S_IDLE;
                ev_ext    = is_ext;
                ev_brk    = is_brk;
                // E0 12 / E0 59 are fake shifts wrapped around some extended keys.
                emit = !(is_ext && (bus.iData == 8'h12 || bus.iData == 8'h59));
                case ({is_ext, bus.iData})
                    {1'b0, 8'h12}: flags_nxt[0] = ~is_brk;
                    {1'b0, 8'h59}: flags_nxt[1] = ~is_brk;
                    {1'b0, 8'h14}: flags_nxt[2] = ~is_brk;
                    {1'b1, 8'h14}: flags_nxt[3] = ~is_brk;
                    {1'b0, 8'h11}: flags_nxt[4] = ~is_brk;
                    {1'b1, 8'h11}: flags_nxt[5] = ~is_brk;
                    default: ;
                endcase
            end
        end
    end

    assign bus.oMod = {flags[5] | flags[4], flags[3] | flags[2], flags[1] | flags[0]};

    assign full = (count == FULL_CNT);
    assign pop  = bus.iAck && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push = emit && (!full || pop);
    assign drop = emit && full && !pop;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ev_ext, ev_brk, ev_key};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.iClr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.oValid    = (count != '0);
    assign bus.oKey      = mem[rd_ptr][7:0];
    assign bus.oBreak    = mem[rd_ptr][8];
    assign bus.oExt      = mem[rd_ptr][9];
    assign bus.oOverflow = overflow;
endmodule

// File: tb/tb_ps2_keyseq_ctrl.sv
// Directed bench for ps2_keyseq_ctrl: scan-byte sequences with hand-computed events, modifiers and FIFO state.
module tb_ps2_keyseq_ctrl;
    logic CLOCK;
    logic RESET;

    ps2_keyseq_ctrl_if bus ();

    ps2_keyseq_ctrl #(
        .DEPTH_LOG2(2),
        .SKIP_PAUSE(7)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for one cycle; returns at the falling edge after it was sampled.
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK);
        bus.iTrig = 1'b1;
        bus.iData = b;
        @(negedge CLOCK);
        bus.iTrig = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge CLOCK);
        bus.iAck = 1'b1;
        @(negedge CLOCK);
        bus.iAck = 1'b0;
    endtask

    task automatic head(input string tag, input logic ext, input logic brk, input logic [7:0] key);
        check({tag, "_vld"}, 32'(bus.oValid), 32'd1);
        check({tag, "_ev"}, {22'd0, bus.oExt, bus.oBreak, bus.oKey}, {22'd0, ext, brk, key});
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    logic [7:0] seq [5];

    initial begin
        seq[0] = 8'h15; seq[1] = 8'h1D; seq[2] = 8'h24; seq[3] = 8'h2D; seq[4] = 8'h2C;
        bus.iTrig = 1'b0;
        bus.iData = 8'h00;
        bus.iAck  = 1'b0;
        bus.iClr  = 1'b0;
        RESET     = 1'b1;
        do_reset();

        check("rst_vld", 32'(bus.oValid), 32'd0);
        check("rst_ev", {22'd0, bus.oExt, bus.oBreak, bus.oKey}, 32'd0);
        check("rst_mod", 32'(bus.oMod), 32'd0);
        check("rst_ovf", 32'(bus.oOverflow), 32'd0);

        // Plain make/break with the consumer always accepting.
        bus.iAck = 1'b1;
        send(8'h1C);
        head("make_1c", 1'b0, 1'b0, 8'h1C);
        send(8'hF0);
        check("f0_no_emit", 32'(bus.oValid), 32'd0);
        send(8'h1C);
        head("brk_1c", 1'b0, 1'b1, 8'h1C);

        // Extended keys and a fake shift.
        send(8'hE0); send(8'h75);
        head("ext_75", 1'b1, 1'b0, 8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        head("extbrk_75", 1'b1, 1'b1, 8'h75);
        send(8'hE0); send(8'h12);
        check("fake_shift", 32'(bus.oValid), 32'd0);
        check("fake_mod", 32'(bus.oMod), 32'd0);
        send(8'hE0); send(8'h75);
        head("ext_75b", 1'b1, 1'b0, 8'h75);

        // Modifier tracking.
        send(8'h12);
        check("mod_lsh", 32'(bus.oMod), 32'd1);
        head("ev_12", 1'b0, 1'b0, 8'h12);
        send(8'hE0); send(8'h14);
        check("mod_rctl", 32'(bus.oMod), 32'd3);
        head("ev_e014", 1'b1, 1'b0, 8'h14);
        send(8'h59);
        check("mod_rsh", 32'(bus.oMod), 32'd3);
        send(8'hF0); send(8'h12);
        check("mod_lsh_up", 32'(bus.oMod), 32'd3);
        head("ev_f012", 1'b0, 1'b1, 8'h12);
        send(8'hF0); send(8'h59);
        check("mod_rsh_up", 32'(bus.oMod), 32'd2);
        send(8'hE0); send(8'hF0); send(8'h14);
        check("mod_clear", 32'(bus.oMod), 32'd0);
        head("ev_rctl_up", 1'b1, 1'b1, 8'h14);
        @(negedge CLOCK);
        check("drain_a", 32'(bus.oValid), 32'd0);

        // Pause sequence: only E1 and the trailing 1C become events.
        bus.iAck = 1'b0;
        send(8'hE1); send(8'h14);
        check("pause_mod", 32'(bus.oMod), 32'd0);
        send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        head("pause_e1", 1'b0, 1'b0, 8'hE1);
        pop_one();
        head("pause_1c", 1'b0, 1'b0, 8'h1C);
        pop_one();
        check("pause_cnt", 32'(bus.oValid), 32'd0);
        check("pause_mod2", 32'(bus.oMod), 32'd0);

        // Overflow: four fit, the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            if (i == 3) check("ovf_before", 32'(bus.oOverflow), 32'd0);
        end
        check("ovf_set", 32'(bus.oOverflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            head($sformatf("ovf_pop%0d", i), 1'b0, 1'b0, seq[i]);
            pop_one();
        end
        check("ovf_empty", 32'(bus.oValid), 32'd0);
        check("ovf_sticky", 32'(bus.oOverflow), 32'd1);
        @(negedge CLOCK);
        bus.iClr = 1'b1;
        @(negedge CLOCK);
        bus.iClr = 1'b0;
        check("ovf_clr", 32'(bus.oOverflow), 32'd0);

        // Full FIFO with push and pop together.
        for (int i = 0; i < 4; i++) send(seq[i]);
        @(negedge CLOCK);
        bus.iTrig = 1'b1;
        bus.iData = 8'h2C;
        bus.iAck  = 1'b1;
        @(negedge CLOCK);
        bus.iTrig = 1'b0;
        bus.iAck  = 1'b0;
        check("pp_no_ovf", 32'(bus.oOverflow), 32'd0);
        for (int i = 1; i < 5; i++) begin
            head($sformatf("pp_pop%0d", i), 1'b0, 1'b0, seq[i]);
            pop_one();
        end
        check("pp_empty", 32'(bus.oValid), 32'd0);

        // Reset in the middle of a prefix.
        send(8'h12);
        send(8'hE0); send(8'hF0);
        do_reset();
        check("rr_mod", 32'(bus.oMod), 32'd0);
        check("rr_vld", 32'(bus.oValid), 32'd0);
        send(8'h1C);
        head("rr_1c", 1'b0, 1'b0, 8'h1C);
        pop_one();
        check("rr_empty", 32'(bus.oValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_keyseq_ctrl.md
Name: ps2_keyseq_ctrl

Overview:
- Sequences the byte stream from the PS/2 byte-read function and assembles scan-code set 2 byte sequences into complete key events.
- Tracks modifier state and buffers events in a small FIFO for the downstream consumer (display/UART logic).
- Sits directly after the PS/2 receiver module: its oTrig/oData feed iTrig/iData here.

Parameters:
- DEPTH_LOG2, 2, log2 of event FIFO depth (depth = 4).
- SKIP_PAUSE, 7, bytes discarded after E1 (pause sequence tail).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- iTrig  in  1  one-cycle strobe; iData valid.
- iData  in  8  received scan byte.
- iAck  in  1  consumer pops FIFO head when oValid=1.
- iClr  in  1  clears oOverflow.
- oValid  out  1  FIFO non-empty.
- oKey  out  8  head event scan code.
- oExt  out  1  head event was E0-prefixed.
- oBreak  out  1  head event is release (F0).
- oMod  out  3  {alt, ctrl, shift}, live modifier state.
- oOverflow  out  1  sticky: event dropped on full FIFO.

Behaviour:
- Reset: state=IDLE, FIFO empty, oValid=0, oKey=0, oExt=0, oBreak=0, oMod=0, oOverflow=0, skip counter=0. Reset mid-sequence discards any partial prefix.
- Decoder FSM advances only on cycles with iTrig=1. States:
  - IDLE: E0->EXT; F0->BRK; E1->emit {key=E1, ext=0, brk=0}, go to SKIP with cnt=SKIP_PAUSE; other->emit {iData,0,0}.
  - EXT: F0->EXTBRK; E0->EXT; other->emit {iData,1,0}, then IDLE.
  - BRK: F0->BRK; E0->EXT; other->emit {iData,0,1}, then IDLE.
  - EXTBRK: F0->EXTBRK; E0->EXT; other->emit {iData,1,1}, then IDLE.
  - SKIP: decrement cnt on each byte; byte that makes cnt reach 0 returns to IDLE. No emits, no reserved-byte check.
- Reserved bytes 00, AA, EE, FA, FC, FD, FE, FF received outside SKIP: discarded, FSM->IDLE, no emit.
- Fake shifts (E0 12, E0 59, make or break) are discarded, FSM->IDLE, no modifier change.
- Modifiers: internal flags LShift(12), RShift(59), LCtrl(14), RCtrl(E0 14), LAlt(11), RAlt(E0 11).
  - Make sets the flag; break clears it.
  - oMod = {LAlt|RAlt, LCtrl|RCtrl, LShift|RShift}, registered, updates the cycle after the final byte.
  - Modifier update happens even if the event is dropped.
- Emit pushes {ext, brk, key} (10 bits) into the FIFO, registered.
  - FIFO empty before the push: oValid and head visible the cycle after the final iTrig (latency 1).
- Pop: iAck=1 with oValid=1 advances head next cycle. iAck with oValid=0 is ignored.
- Full FIFO with push and no pop: event dropped, oOverflow<=1.
- Full FIFO with simultaneous push and pop: both occur, no overflow.
- Empty FIFO: iAck ignored.
- Pointers wrap modulo depth. Count width is DEPTH_LOG2+1.
- iClr=1 clears oOverflow next cycle. An overflow in the same cycle wins (oOverflow stays 1).
- oKey/oExt/oBreak always reflect the head slot. They are don't-care when oValid=0, but held stable (no glitch) while oValid=1 and no pop.

Test Plan:
- Bytes 1C, F0 1C with iAck held 1 -> events {1C,ext0,brk0} then {1C,ext0,brk1}; oValid rises 1 cycle after each final iTrig.
- E0 75, E0 F0 75 -> {75,1,0}, {75,1,1}; E0 12 E0 75 -> only {75,1,0} emitted.
- 12 (LShift make), E0 14 (RCtrl make) -> oMod=3'b011; 59 -> oMod stays 011; F0 12 -> oMod still 011 (RShift held); F0 59 then E0 F0 14 -> oMod=000. Every byte also emits its event.
- Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 1C -> exactly two events {E1,0,0} and {1C,0,0}; oMod unchanged by the embedded 14.
- iAck=0, send 5 make codes 15 1D 24 2D 2C -> 4 buffered in order, 5th dropped, oOverflow=1. Pop all 4 -> oValid=0. iClr -> oOverflow=0.
- FIFO full, push and iAck in the same cycle -> count stays 4, no overflow. Assert RESET after E0 F0 -> next byte 1C yields {1C,0,0}, oMod=0.
